// File: rtl/pmp_pkg.sv
// pmp_pkg: shared encodings and helpers for the PMP access sequencer
package pmp_pkg;
  localparam logic [1:0] OPER_READ  = 2'b00;
  localparam logic [1:0] OPER_WRITE = 2'b01;
  localparam logic [1:0] OPER_EXEC  = 2'b10;
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] PERM_DENY  = 2'b00;
  localparam logic [1:0] PERM_GRANT = 2'b01;
  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t CHECK = 2'd1;
  localparam state_t RESP  = 2'd2;
  localparam state_t FENCE = 2'd3;
  typedef enum logic {IF = 1'b0, LS = 1'b1} owner_e;
  function automatic logic misaligned(logic [1:0] lsb, logic [1:0] size);
    return (size == SIZE_H && lsb[0]) || (size == SIZE_W && lsb != 2'b00);
  endfunction
endpackage

// File: rtl/pmp_rr_arb.sv
// pmp_rr_arb: 2-way round-robin arbiter, bit0 = fetch, bit1 = load/store
module pmp_rr_arb (
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       en,
  output logic [1:0] grant
);
  // on a contest the requester that did not win last time takes the port
  always_comb begin
    grant = !en ? 2'b00 : valid == 2'b11 ? (last_grant ? 2'b01 : 2'b10) : valid;
  end
endmodule

// File: rtl/pmp_access_ctrl.sv
// pmp_access_ctrl: shares one PMP check port between fetch and load/store requesters
module pmp_access_ctrl
  import pmp_pkg::*;
#(
  parameter int unsigned FENCE_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_req_addr,
  input  logic [1:0]  if_req_priv,
  output logic        if_rsp_valid,
  input  logic        if_rsp_ready,
  output logic        if_rsp_fault,
  input  logic        ls_req_valid,
  output logic        ls_req_ready,
  input  logic [31:0] ls_req_addr,
  input  logic [1:0]  ls_req_oper,
  input  logic [1:0]  ls_req_size,
  input  logic [1:0]  ls_req_priv,
  output logic        ls_rsp_valid,
  input  logic        ls_rsp_ready,
  output logic        ls_rsp_fault,
  input  logic        csr_wr_en,
  output logic [31:0] pmp_addr,
  output logic [1:0]  pmp_oper,
  output logic [1:0]  pmp_size,
  output logic [1:0]  pmp_priv,
  input  logic [1:0]  pmp_permission,
  output logic        busy
);
  localparam int FW = $clog2(FENCE_CYCLES + 1) < 1 ? 1 : $clog2(FENCE_CYCLES + 1);
  state_t state_q, state_d;
  logic [FW-1:0] fence_cnt_q, fence_cnt_d;
  owner_e last_grant_q, last_grant_d, owner_q, owner_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0] oper_q, oper_d, size_q, size_d, priv_q, priv_d;
  logic fault_q, fault_d;
  logic [1:0] grant;
  logic in_resp, rsp_fire;
  pmp_rr_arb u_arb (
    .valid      ({ls_req_valid, if_req_valid}),
    .last_grant (last_grant_q == LS),
    .en         (state_q == IDLE && fence_cnt_q == '0),
    .grant      (grant)
  );
  assign if_req_ready = grant[0];
  assign ls_req_ready = grant[1];
  assign in_resp = state_q == RESP;
  assign if_rsp_valid = in_resp && owner_q == IF;
  assign ls_rsp_valid = in_resp && owner_q == LS;
  assign if_rsp_fault = if_rsp_valid && fault_q;
  assign ls_rsp_fault = ls_rsp_valid && fault_q;
  assign rsp_fire = (if_rsp_valid && if_rsp_ready) || (ls_rsp_valid && ls_rsp_ready);
  assign pmp_addr = addr_q;
  assign pmp_oper = oper_q;
  assign pmp_size = size_q;
  assign pmp_priv = priv_q;
  assign busy = state_q != IDLE || fence_cnt_q != '0;
  // sequence capture, check, response and post-CSR-write fence
  always_comb begin
    state_d = state_q;
    last_grant_d = last_grant_q;
    owner_d = owner_q;
    addr_d = addr_q;
    oper_d = oper_q;
    size_d = size_q;
    priv_d = priv_q;
    fault_d = fault_q;
    fence_cnt_d = csr_wr_en ? FW'(FENCE_CYCLES) : fence_cnt_q != '0 ? fence_cnt_q - FW'(1) : fence_cnt_q;
    unique case (state_q)
      IDLE: if (grant != 2'b00) begin
        state_d = CHECK;
        owner_d = grant[1] ? LS : IF;
        last_grant_d = grant[1] ? LS : IF;
        addr_d = grant[1] ? ls_req_addr : if_req_addr;
        oper_d = grant[1] ? ls_req_oper : OPER_EXEC;
        size_d = grant[1] ? ls_req_size : SIZE_W;
        priv_d = grant[1] ? ls_req_priv : if_req_priv;
      end
      CHECK: begin
        state_d = csr_wr_en ? FENCE : RESP;
        fault_d = csr_wr_en ? fault_q : (pmp_permission != PERM_GRANT) || misaligned(addr_q[1:0], size_q) || size_q == 2'b11;
      end
      RESP: state_d = rsp_fire ? IDLE : RESP;
      default: state_d = fence_cnt_q == '0 ? CHECK : FENCE;
    endcase
  end
  // state registers, cleared asynchronously
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      fence_cnt_q <= '0;
      last_grant_q <= LS;
      owner_q <= IF;
      addr_q <= '0;
      oper_q <= '0;
      size_q <= '0;
      priv_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fence_cnt_q <= fence_cnt_d;
      last_grant_q <= last_grant_d;
      owner_q <= owner_d;
      addr_q <= addr_d;
      oper_q <= oper_d;
      size_q <= size_d;
      priv_q <= priv_d;
      fault_q <= fault_d;
    end
  end
endmodule

// File: tb/tb_pmp_access_ctrl.sv
// tb_pmp_access_ctrl: directed and random checks against a transaction-level model
module tb_pmp_access_ctrl;
  localparam int FC = 2;
  logic clock = 1'b0, reset = 1'b1;
  logic if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready, if_rsp_fault;
  logic [31:0] if_req_addr, ls_req_addr, pmp_addr;
  logic [1:0] if_req_priv, ls_req_oper, ls_req_size, ls_req_priv;
  logic ls_req_valid, ls_req_ready, ls_rsp_valid, ls_rsp_ready, ls_rsp_fault;
  logic csr_wr_en, busy;
  logic [1:0] pmp_oper, pmp_size, pmp_priv, pmp_permission;
  logic [1:0] tbl [8];
  int total = 0, bad = 0;

  pmp_access_ctrl #(.FENCE_CYCLES(FC)) dut (
    .clock(clock), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_req_priv(if_req_priv), .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready),
    .if_rsp_fault(if_rsp_fault), .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready),
    .ls_req_addr(ls_req_addr), .ls_req_oper(ls_req_oper), .ls_req_size(ls_req_size),
    .ls_req_priv(ls_req_priv), .ls_rsp_valid(ls_rsp_valid), .ls_rsp_ready(ls_rsp_ready),
    .ls_rsp_fault(ls_rsp_fault), .csr_wr_en(csr_wr_en), .pmp_addr(pmp_addr),
    .pmp_oper(pmp_oper), .pmp_size(pmp_size), .pmp_priv(pmp_priv),
    .pmp_permission(pmp_permission), .busy(busy)
  );

  // the PMP itself: permission looked up by address region
  assign pmp_permission = tbl[pmp_addr[14:12]];
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit model_fault(input logic [31:0] a, input logic [1:0] sz);
    return (tbl[a[14:12]] != 2'b01) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00) || sz == 2'b11;
  endfunction

  bit outst = 0, own = 0, clean = 0, seen = 0, efault = 0, last = 1;
  logic [31:0] m_addr = '0;
  logic [1:0] m_oper = '0, m_size = '0, m_priv = '0;
  int hs = 0, cyc = 0, fence_left = 0;

  // one outstanding transaction at a time; compare every cycle, then advance the model
  always @(negedge clock) begin : cmp
    bit er_if, er_ls, rv_own, rv_oth, rr_own;
    cyc++;
    if (reset) begin
      outst = 0; m_addr = '0; m_oper = '0; m_size = '0; m_priv = '0; fence_left = 0; last = 1;
      chk("rst_busy", busy, 0);
      chk("rst_rdy", {if_req_ready, ls_req_ready}, 0);
      chk("rst_rsp", {if_rsp_valid, ls_rsp_valid, if_rsp_fault, ls_rsp_fault}, 0);
      chk("rst_pmp", {pmp_oper, pmp_size, pmp_priv}, 0);
      chk("rst_addr", pmp_addr, 0);
    end else begin
      er_if = !outst && fence_left == 0 && if_req_valid && (!ls_req_valid || last);
      er_ls = !outst && fence_left == 0 && ls_req_valid && (!if_req_valid || !last);
      chk("if_ready", if_req_ready, er_if);
      chk("ls_ready", ls_req_ready, er_ls);
      chk("busy", busy, outst || fence_left != 0);
      chk("pmp_addr", pmp_addr, m_addr);
      chk("pmp_ctl", {pmp_oper, pmp_size, pmp_priv}, {m_oper, m_size, m_priv});
      rv_own = own ? ls_rsp_valid : if_rsp_valid;
      rv_oth = own ? if_rsp_valid : ls_rsp_valid;
      rr_own = own ? ls_rsp_ready : if_rsp_ready;
      if (!outst) chk("rsp_idle", {if_rsp_valid, ls_rsp_valid}, 0);
      else begin
        chk("rsp_other", rv_oth, 0);
        if (clean) chk("rsp_latency", rv_own, cyc - hs >= 2);
        else if (seen) chk("rsp_hold", rv_own, 1);
        if (rv_own) begin
          if (!seen) begin seen = 1; efault = model_fault(m_addr, m_size); end
          chk("rsp_fault", own ? ls_rsp_fault : if_rsp_fault, efault);
        end
        if (cyc - hs > 60) begin
          bad++; total++; outst = 0;
          $display("FAIL rsp_timeout: waited %0d cycles, limit 60", cyc - hs);
        end
      end
      if (outst && rv_own && rr_own) outst = 0;
      if (outst && cyc == hs + 1 && csr_wr_en) clean = 0;
      if (er_if || er_ls) begin
        outst = 1; own = er_ls; last = er_ls; hs = cyc; clean = 1; seen = 0;
        m_addr = er_ls ? ls_req_addr : if_req_addr;
        m_oper = er_ls ? ls_req_oper : 2'b10;
        m_size = er_ls ? ls_req_size : 2'b10;
        m_priv = er_ls ? ls_req_priv : if_req_priv;
      end
      fence_left = csr_wr_en ? FC : fence_left > 0 ? fence_left - 1 : 0;
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (!busy) begin next_cycle(); return; end
    end
    total++; bad++;
    $display("FAIL idle_timeout: busy still %0b after 60 cycles", busy);
    next_cycle();
  endtask

  initial begin
    int lat;
    bit seq [$];
    {if_req_valid, ls_req_valid, if_rsp_ready, ls_rsp_ready, csr_wr_en} = '0;
    {if_req_addr, ls_req_addr} = '0;
    {if_req_priv, ls_req_oper, ls_req_size, ls_req_priv} = '0;
    for (int i = 0; i < 8; i++) tbl[i] = 2'b01;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    // fetch at 0x1000, granted
    if_req_valid = 1; if_req_addr = 32'h1000; if_req_priv = 2'd3; if_rsp_ready = 1; ls_rsp_ready = 1;
    @(negedge clock); chk("t1_ready", if_req_ready, 1);
    next_cycle(); if_req_valid = 0;
    @(negedge clock);
    chk("t1_oper", pmp_oper, 2'b10);
    chk("t1_addr", pmp_addr, 32'h1000);
    chk("t1_early", if_rsp_valid, 0);
    @(negedge clock);
    chk("t1_valid", if_rsp_valid, 1);
    chk("t1_fault", if_rsp_fault, 0);
    wait_idle();
    // contest right after reset: IF, LS, IF
    reset = 1; next_cycle(); reset = 0;
    if_req_valid = 1; ls_req_valid = 1; ls_req_addr = 32'h2000; ls_req_oper = 2'b01; ls_req_size = 2'b10;
    for (int k = 0; k < 9; k++) begin
      @(negedge clock);
      if (if_req_ready || ls_req_ready) seq.push_back(ls_req_ready);
    end
    chk("t2_count", seq.size(), 3);
    if (seq.size() == 3) begin
      chk("t2_first", seq[0], 0);
      chk("t2_second", seq[1], 1);
      chk("t2_third", seq[2], 0);
    end
    next_cycle(); if_req_valid = 0; ls_req_valid = 0;
    wait_idle();
    // misaligned word write
    ls_req_valid = 1; ls_req_addr = 32'h2002; ls_req_oper = 2'b01; ls_req_size = 2'b10;
    @(negedge clock); chk("t3_ready", ls_req_ready, 1);
    next_cycle(); ls_req_valid = 0;
    @(negedge clock);
    @(negedge clock);
    chk("t3_valid", ls_rsp_valid, 1);
    chk("t3_fault", ls_rsp_fault, 1);
    wait_idle();
    // CSR write during CHECK: discard, fence, re-check with denied permission
    if_req_valid = 1; if_req_addr = 32'h3000;
    @(negedge clock); chk("t4_ready", if_req_ready, 1);
    next_cycle(); if_req_valid = 0; csr_wr_en = 1;
    next_cycle(); csr_wr_en = 0; tbl[3] = 2'b00;
    lat = 0;
    for (int k = 2; k < 30; k++) begin
      @(negedge clock);
      if (if_rsp_valid) begin lat = k; break; end
    end
    chk("t4_latency", lat, 6);
    chk("t4_fault", if_rsp_fault, 1);
    wait_idle();
    // response held while not consumed
    tbl[4] = 2'b00; if_rsp_ready = 0;
    if_req_valid = 1; if_req_addr = 32'h4000;
    @(negedge clock); chk("t5_ready", if_req_ready, 1);
    next_cycle(); if_req_valid = 0; ls_req_valid = 1; ls_req_addr = 32'h0; ls_req_size = 2'b00;
    @(negedge clock);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("t5_valid", if_rsp_valid, 1);
      chk("t5_fault", if_rsp_fault, 1);
      chk("t5_busy", busy, 1);
      chk("t5_nogrant", ls_req_ready, 0);
    end
    next_cycle(); if_rsp_ready = 1; ls_req_valid = 0;
    wait_idle();
    // asynchronous reset during CHECK
    if_req_valid = 1; if_req_addr = 32'h1000;
    @(negedge clock); chk("t6_ready", if_req_ready, 1);
    next_cycle(); if_req_valid = 0; reset = 1;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_addr", pmp_addr, 0);
    chk("t6_oper", pmp_oper, 0);
    next_cycle(); reset = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("t6_norsp", if_rsp_valid, 0);
      chk("t6_idle", busy, 0);
    end
    next_cycle();
    // random traffic with occasional CSR writes that reshuffle the PMP table
    for (int n = 0; n < 3000; n++) begin
      if (csr_wr_en) for (int i = 0; i < 8; i++) tbl[i] = ($urandom_range(0, 2) != 0) ? 2'b01 : 2'($urandom_range(0, 3));
      if_req_valid = $urandom_range(0, 2) != 0;
      ls_req_valid = $urandom_range(0, 2) != 0;
      if_req_addr = {17'h0, 3'($urandom), 10'($urandom), 2'($urandom)};
      ls_req_addr = {17'h0, 3'($urandom), 10'($urandom), 2'($urandom)};
      if_req_priv = 2'($urandom);
      ls_req_priv = 2'($urandom);
      ls_req_oper = 2'($urandom_range(0, 1));
      ls_req_size = 2'($urandom);
      if_rsp_ready = $urandom_range(0, 3) != 0;
      ls_rsp_ready = $urandom_range(0, 3) != 0;
      csr_wr_en = $urandom_range(0, 11) == 0;
      next_cycle();
    end
    {if_req_valid, ls_req_valid, csr_wr_en} = '0;
    if_rsp_ready = 1; ls_rsp_ready = 1;
    wait_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
